rr_arbiter_4: RTL and testbench

- Four-requester round-robin arbiter that shares one downstream resource (bus/datapath port) among requesters 0..3.
- Outputs a one-hot grant and its 2-bit encoded index (same 4:2 encoding as the combinational encoder: one-hot 0001→00, 0010→01, 0100→10, 1000→11).
- Enforces a bounded tenure so no requester can monopolise the resource.
- Sits between requester agents and the shared resource mux; grant_idx drives the mux select directly.

---
 rtl/rr_arbiter_4.sv | 111 +++++++++++
 tb/tb_rr_arbiter_4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded tenure per owner.
// Registered one-hot grant plus encoded index that drives the shared-resource mux select.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;

  logic [3:0] others;
  logic [1:0] win_all, win_oth, win;
  logic       expired, load, clear;

  // First set bit of r searching p, p+1, ... modulo 4; the lowest offset wins.
  function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] i;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      i = p + k[1:0];
      if (r[i]) w = i;
    end
    return w;
  endfunction

  always_comb begin
    others  = req & ~grant_q;
    win_all = arb(req, ptr_q);
    win_oth = arb(others, ptr_q);
    expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
    load    = 1'b0;
    clear   = 1'b0;
    win     = win_all;
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: load = |req;
      default: begin
        if (!req[idx_q]) begin
          load  = |req;
          clear = ~|req;
        end else if (expired) begin
          // Tenure is up: hand over to a waiting requester, or restart the count.
          cnt_d = '0;
          load  = |others;
          win   = win_oth;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (load) begin
      state_d = S_BUSY;
      grant_d = 4'b0001 << win;
      idx_d   = win;
      valid_d = 1'b1;
      cnt_d   = '0;
      ptr_d   = win + 2'd1;
    end else if (clear) begin
      state_d = S_IDLE;
      grant_d = 4'b0000;
      idx_d   = 2'b00;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: vector table, hand-written multi-cycle sequences,
// and random traffic checked against an integer-level model of the arbitration rules.
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  // Model state: owner index or -1 when idle, next search start, cycles held.
  int m_own, m_ptr, m_cnt;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] i, input logic v);
    chk({name, ".grant"}, int'(grant), int'(g));
    chk({name, ".idx"}, int'(grant_idx), int'(i));
    chk({name, ".valid"}, int'(grant_valid), int'(v));
  endtask

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    int w;
    logic [3:0] oth;
    if (m_own < 0 || !r[m_own]) begin
      w = search(r, m_ptr);
      m_own = w;
      m_cnt = 0;
      if (w >= 0) m_ptr = (w + 1) % 4;
    end else if (m_cnt == MAX_HOLD - 1) begin
      oth = r;
      oth[m_own] = 1'b0;
      m_cnt = 0;
      w = search(oth, m_ptr);
      if (w >= 0) begin
        m_own = w;
        m_ptr = (w + 1) % 4;
      end
    end else begin
      m_cnt++;
    end
  endtask

  // Advance one edge with the current req; outputs are sampled 1ns after the edge.
  task automatic step();
    model_step(req);
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string name);
    logic [3:0] g;
    g = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
    chk_out(name, g, (m_own < 0) ? 2'd0 : 2'(m_own), m_own >= 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_own = -1; m_ptr = 0; m_cnt = 0;
  endtask

  vec_t tv[$];

  initial begin
    m_own = -1; m_ptr = 0; m_cnt = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Reset release tie-break, rotation with release, single requester, idle.
    tv.push_back('{4'b1111, 4'b0001, 2'd0, 1'b1});
    tv.push_back('{4'b1110, 4'b0010, 2'd1, 1'b1});
    tv.push_back('{4'b1101, 4'b0100, 2'd2, 1'b1});
    tv.push_back('{4'b1011, 4'b1000, 2'd3, 1'b1});
    tv.push_back('{4'b0111, 4'b0001, 2'd0, 1'b1});
    tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1});
    tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
    tv.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
    foreach (tv[n]) begin
      req = tv[n].req;
      step();
      chk_out($sformatf("vec%0d", n), tv[n].grant, tv[n].idx, tv[n].valid);
    end

    // Tenure pre-emption between two constant requesters.
    do_reset();
    req = 4'b0011;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (((k - 1) / MAX_HOLD) % 2 == 0) chk_out($sformatf("tenure%0d", k), 4'b0001, 2'd0, 1'b1);
      else                               chk_out($sformatf("tenure%0d", k), 4'b0010, 2'd1, 1'b1);
    end

    // Tenure expiry with no competitor: owner keeps the grant.
    req = 4'b0000;
    step();
    req = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_out($sformatf("solo%0d", k), 4'b1000, 2'd3, 1'b1);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0100;
    step();
    chk_out("pre_areset", 4'b0100, 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("areset", 4'b0000, 2'd0, 1'b0);
    req = 4'b0110;
    #1 rst_n = 1'b1;
    m_own = -1; m_ptr = 0; m_cnt = 0;
    step();
    chk_out("post_areset", 4'b0010, 2'd1, 1'b1);

    // Random traffic against the model; bias toward sticky requests so tenure expiry occurs.
    do_reset();
    req = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else if ($urandom_range(0, 5) == 0 && m_own >= 0) req[m_own] = 1'b0;
      step();
      model_check($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
